// File: rtl/tag_sort_pkg.sv
// Shared types and sizing for the multibit tag-sort tree search engine.
package tag_sort_pkg;
  localparam int W_DEF = 16;
  localparam int N_DEF = 4;
  localparam int LOG2W = $clog2(W_DEF);
  localparam int TAG_W = N_DEF + LOG2W;

  typedef enum logic [2:0] {IDLE, ROOT, RD, LEAF, DONE} state_t;
endpackage

// File: rtl/lsb_first_enc.sv
// Combinational priority encoder: index of the lowest set bit, plus found flag.
module lsb_first_enc #(
  parameter int W = 16,
  localparam int LW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [LW-1:0] o_idx,
  output logic          o_found
);
  // Scan high to low so the last hit, the lowest index, wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = LW'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tree_min_search.sv
// Minimum-tag search: lowest root bit selects a layer-2 node, lowest node bit
// selects the leaf; result is {node, leaf}.
module tree_min_search
  import tag_sort_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [W-1:0]               root_bitmap,
  output logic                       mem_ena,
  output logic [N-1:0]               mem_addr,
  input  logic [W-1:0]               mem_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [N+$clog2(W)-1:0]     res_tag,
  output logic                       res_empty,
  output logic                       res_err
);
  localparam int LW    = $clog2(W);
  localparam int TW    = N + LW;
  localparam int NODES = 1 << N;

  state_t         r_state;
  logic           r_found;
  logic [N-1:0]   r_node;
  logic           r_mem_ena;
  logic [N-1:0]   r_mem_addr;
  logic [TW-1:0]  r_tag;
  logic           r_empty;
  logic           r_err;

  logic [W-1:0]   w_root_mask;
  logic [W-1:0]   w_root_vec;
  logic [LW-1:0]  w_root_idx;
  logic           w_root_found;
  logic [LW-1:0]  w_leaf_idx;
  logic           w_leaf_found;

  // Root bits beyond the node count have no backing node and are ignored.
  always_comb begin
    w_root_mask = '0;
    for (int i = 0; i < W; i++) w_root_mask[i] = (i < NODES);
  end
  assign w_root_vec = root_bitmap & w_root_mask;

  lsb_first_enc #(.W(W)) u_root_enc (
    .i_vec   (w_root_vec),
    .o_idx   (w_root_idx),
    .o_found (w_root_found)
  );

  lsb_first_enc #(.W(W)) u_leaf_enc (
    .i_vec   (mem_data),
    .o_idx   (w_leaf_idx),
    .o_found (w_leaf_found)
  );

  // Root is encoded at accept time so the read strobe is a registered output
  // that lands exactly on the ROOT cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_found    <= 1'b0;
      r_node     <= '0;
      r_mem_ena  <= 1'b0;
      r_mem_addr <= '0;
      r_tag      <= '0;
      r_empty    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_found   <= w_root_found;
          r_node    <= N'(w_root_idx);
          r_mem_ena <= w_root_found;
          if (w_root_found) r_mem_addr <= N'(w_root_idx);
          r_state   <= ROOT;
        end
        ROOT: begin
          r_mem_ena <= 1'b0;
          if (!r_found) begin
            r_empty <= 1'b1;
            r_tag   <= '0;
            r_state <= DONE;
          end else begin
            r_state <= RD;
          end
        end
        RD:   r_state <= LEAF;
        // Encoder yields index 0 on an all-zero node, giving {node, 0} on error.
        LEAF: begin
          r_tag   <= {r_node, w_leaf_idx};
          r_err   <= ~w_leaf_found;
          r_state <= DONE;
        end
        DONE: if (res_ready) begin
          r_tag   <= '0;
          r_empty <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign res_valid = (r_state == DONE);
  assign mem_ena   = r_mem_ena;
  assign mem_addr  = r_mem_addr;
  assign res_tag   = r_tag;
  assign res_empty = r_empty;
  assign res_err   = r_err;
endmodule

// File: tb/tb_tree_min_search.sv
// Scoreboard bench for tree_min_search: expected results queued at request time.
module tb_tree_min_search;
  typedef struct packed {
    logic [7:0] tag;
    logic       empty;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] root_bitmap;
  logic        mem_ena;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data = '0;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_tag;
  logic        res_empty;
  logic        res_err;

  logic [15:0] node_mem [16];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;

  tree_min_search #(.W(16), .N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .root_bitmap (root_bitmap),
    .mem_ena     (mem_ena),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_tag     (res_tag),
    .res_empty   (res_empty),
    .res_err     (res_err)
  );

  always #5 clk = ~clk;

  // Layer-2 memory: registered read port, data holds until the next read.
  always @(posedge clk) if (mem_ena) mem_data <= node_mem[mem_addr];

  function automatic exp_t model(input logic [15:0] root);
    exp_t        e;
    logic [15:0] iso;
    logic [15:0] nd;
    logic [3:0]  ni;
    logic [3:0]  li;
    e = '0;
    if (root == 0) begin
      e.empty = 1'b1;
    end else begin
      iso = root & (~root + 16'd1);
      ni  = 4'($clog2(iso));
      nd  = node_mem[ni];
      if (nd == 0) begin
        e.err = 1'b1;
        li    = 4'd0;
      end else begin
        iso = nd & (~nd + 16'd1);
        li  = 4'($clog2(iso));
      end
      e.tag = {ni, li};
    end
    return e;
  endfunction

  task automatic issue(input logic [15:0] root);
    @(negedge clk);
    req_valid   = 1'b1;
    root_bitmap = root;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    root_bitmap = 16'hFFFF;
  endtask

  task automatic wait_result(output int lat, output int ena_cyc, output logic [3:0] ena_addr,
                             output int ena_cnt);
    lat = -1; ena_cyc = -1; ena_addr = 'x; ena_cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (mem_ena) begin
        ena_cnt++;
        ena_cyc  = cyc;
        ena_addr = mem_addr;
      end
      if (res_valid) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; res_ready = 1'b0; root_bitmap = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, mem_ena, mem_addr, res_valid, res_tag, res_empty, res_err} !== {1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b ena=%b addr=%0d vld=%b tag=%h emp=%b err=%b, want rdy=1 rest 0",
               req_ready, mem_ena, mem_addr, res_valid, res_tag, res_empty, res_err);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_ena, res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b ena=%b vld=%b, want 1 0 0", req_ready, mem_ena, res_valid);
    end
  endtask

  task automatic test_basic();
    int lat, ec, cnt; logic [3:0] ea; exp_t e;
    node_mem[4] = 16'h0100;
    sb.push_back('{tag: 8'h48, empty: 1'b0, err: 1'b0});
    issue(16'h0010);
    wait_result(lat, ec, ea, cnt);
    checks++;
    if (cnt !== 1 || ec !== 1 || ea !== 4'd4) begin
      errors++;
      $display("FAIL basic_mem: got cnt=%0d cyc=%0d addr=%0d, want 1 1 4", cnt, ec, ea);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    e = sb.pop_front();
    checks++;
    if ({res_tag, res_empty, res_err} !== e) begin
      errors++;
      $display("FAIL basic_result: got tag=%h emp=%b err=%b want tag=%h emp=%b err=%b",
               res_tag, res_empty, res_err, e.tag, e.empty, e.err);
    end
    ack();
  endtask

  task automatic test_empty();
    int lat, ec, cnt; logic [3:0] ea; exp_t e;
    sb.push_back('{tag: 8'h00, empty: 1'b1, err: 1'b0});
    issue(16'h0000);
    wait_result(lat, ec, ea, cnt);
    checks++;
    if (cnt !== 0 || lat !== 2) begin
      errors++;
      $display("FAIL empty_timing: got ena_cnt=%0d lat=%0d want 0 2", cnt, lat);
    end
    e = sb.pop_front();
    checks++;
    if ({res_tag, res_empty, res_err} !== e) begin
      errors++;
      $display("FAIL empty_result: got tag=%h emp=%b err=%b want tag=%h emp=%b err=%b",
               res_tag, res_empty, res_err, e.tag, e.empty, e.err);
    end
    ack();
    @(negedge clk);
    checks++;
    if ({res_valid, res_empty, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL empty_clear: got vld=%b emp=%b rdy=%b want 0 0 1", res_valid, res_empty, req_ready);
    end
  endtask

  task automatic test_hold();
    int lat, ec, cnt, bad; logic [3:0] ea; exp_t e;
    node_mem[0] = 16'h8000;
    sb.push_back('{tag: 8'h0F, empty: 1'b0, err: 1'b0});
    issue(16'h8001);
    wait_result(lat, ec, ea, cnt);
    checks++;
    if (cnt !== 1 || ea !== 4'd0 || lat !== 4) begin
      errors++;
      $display("FAIL hold_path: got cnt=%0d addr=%0d lat=%0d want 1 0 4", cnt, ea, lat);
    end
    req_valid = 1'b1; root_bitmap = 16'h0010;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!res_valid || req_ready || mem_ena || res_tag !== 8'h0F || res_empty || res_err) bad++;
    end
    req_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    end
    e = sb.pop_front();
    checks++;
    if ({res_tag, res_empty, res_err} !== e) begin
      errors++;
      $display("FAIL hold_result: got tag=%h emp=%b err=%b want tag=%h", res_tag, res_empty, res_err, e.tag);
    end
    ack();
    @(negedge clk);
    checks++;
    if ({res_valid, req_ready, mem_ena} !== 3'b010) begin
      errors++;
      $display("FAIL hold_release: got vld=%b rdy=%b ena=%b want 0 1 0", res_valid, req_ready, mem_ena);
    end
  endtask

  task automatic test_err();
    int lat, ec, cnt; logic [3:0] ea; exp_t e;
    node_mem[2] = 16'h0000;
    sb.push_back('{tag: 8'h20, empty: 1'b0, err: 1'b1});
    issue(16'h0004);
    wait_result(lat, ec, ea, cnt);
    checks++;
    if (cnt !== 1 || ea !== 4'd2 || lat !== 4) begin
      errors++;
      $display("FAIL err_path: got cnt=%0d addr=%0d lat=%0d want 1 2 4", cnt, ea, lat);
    end
    e = sb.pop_front();
    checks++;
    if ({res_tag, res_empty, res_err} !== e) begin
      errors++;
      $display("FAIL err_result: got tag=%h emp=%b err=%b want tag=%h emp=%b err=%b",
               res_tag, res_empty, res_err, e.tag, e.empty, e.err);
    end
    ack();
    @(negedge clk);
    checks++;
    if (res_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", res_err); end
  endtask

  task automatic test_reset_mid();
    int lat, ec, cnt, bad; logic [3:0] ea; exp_t e;
    node_mem[3] = 16'h0040;
    node_mem[1] = 16'h0001;
    issue(16'h0008);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, res_valid, mem_ena, mem_addr, res_tag} !== {1'b1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL midreset_state: got rdy=%b vld=%b ena=%b addr=%0d tag=%h want 1 0 0 0 00",
               req_ready, res_valid, mem_ena, mem_addr, res_tag);
    end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid || mem_ena || !req_ready) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", bad); end
    sb.push_back('{tag: 8'h10, empty: 1'b0, err: 1'b0});
    issue(16'h0002);
    wait_result(lat, ec, ea, cnt);
    checks++;
    if (cnt !== 1 || ea !== 4'd1 || lat !== 4) begin
      errors++;
      $display("FAIL midreset_fresh: got cnt=%0d addr=%0d lat=%0d want 1 1 4", cnt, ea, lat);
    end
    e = sb.pop_front();
    checks++;
    if ({res_tag, res_empty, res_err} !== e) begin
      errors++;
      $display("FAIL midreset_result: got tag=%h want tag=%h", res_tag, e.tag);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    int prev_hs, results, bad_gap;
    logic prev_empty, take;
    exp_t e;
    for (int i = 0; i < 16; i++) node_mem[i] = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
    prev_hs = -1; prev_empty = 1'b0; results = 0; bad_gap = 0;
    res_ready = 1'b1; req_valid = 1'b1; root_bitmap = 16'h0001;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      take = 1'b0;
      if (res_valid) begin
        results++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: got tag=%h with empty scoreboard", res_tag);
        end else begin
          e = sb.pop_front();
          if ({res_tag, res_empty, res_err} !== e) begin
            errors++;
            $display("FAIL b2b_result: got tag=%h emp=%b err=%b want tag=%h emp=%b err=%b",
                     res_tag, res_empty, res_err, e.tag, e.empty, e.err);
          end
        end
      end
      if (req_ready) begin
        sb.push_back(model(root_bitmap));
        if (prev_hs >= 0 && (cyc - prev_hs) != (prev_empty ? 3 : 5)) bad_gap++;
        prev_hs    = cyc;
        prev_empty = (root_bitmap == 0);
        take       = 1'b1;
      end
      @(posedge clk);
      #1;
      if (take) begin
        case ($urandom_range(0, 3))
          0:       root_bitmap = 16'h0;
          1:       root_bitmap = 16'h1 << $urandom_range(0, 15);
          default: root_bitmap = 16'($urandom);
        endcase
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (res_valid) begin
        e = sb.pop_front();
        checks++;
        if ({res_tag, res_empty, res_err} !== e) begin
          errors++;
          $display("FAIL b2b_drain: got tag=%h emp=%b err=%b want tag=%h", res_tag, res_empty, res_err, e.tag);
        end
      end
    end
    res_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d pending want 0", sb.size()); end
    checks++;
    if (bad_gap != 0 || results < 30) begin
      errors++;
      $display("FAIL b2b_throughput: got bad_gaps=%0d results=%0d want 0 and >=30", bad_gap, results);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) node_mem[i] = '0;
    test_reset();
    test_basic();
    test_empty();
    test_hold();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
